// File: rtl/pong_pkg.sv
// Purpose: shared types and constants for the pong game sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: match state encoding, direction constants, coordinate widths,
// and a span-overlap helper used for the paddle hit tests.
package pong_pkg;

  localparam int X_W     = 10;  // ball_x width
  localparam int Y_W     = 9;   // ball_y / paddle y width
  localparam int SCORE_W = 4;
  localparam int CTR_W   = 8;   // serve delay counter
  localparam int CALC_W  = 12;  // headroom for x+size+speed sums

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  // True when [a_lo, a_lo+a_len) and [b_lo, b_lo+b_len) share at least one pixel.
  function automatic logic span_overlap(
    input logic [CALC_W-1:0] a_lo,
    input logic [CALC_W-1:0] a_len,
    input logic [CALC_W-1:0] b_lo,
    input logic [CALC_W-1:0] b_len
  );
    return ((a_lo + a_len) > b_lo) && (a_lo < (b_lo + b_len));
  endfunction

endpackage

// File: rtl/pong_paddle.sv
// Purpose: one paddle's vertical position, stepped once per enabled tick.
// Latency: new y visible 1 clk after tick.
// Backpressure: none; up and dn together (or neither) hold position.
//
// Ports: clk, rst_n (async active-low); tick (frame pulse); en (movement
// allowed); up, dn (player levels); y (paddle top edge, saturates 0..CLAMP_MAX).
module pong_paddle
  import pong_pkg::*;
#(
  parameter int STEP      = 4,
  parameter int CLAMP_MAX = 416,
  parameter int Y_RST     = 208
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic           en,
  input  logic           up,
  input  logic           dn,
  output logic [Y_W-1:0] y
);

  localparam logic [Y_W-1:0] C_STEP = Y_W'(STEP);
  localparam logic [Y_W-1:0] C_MAX  = Y_W'(CLAMP_MAX);
  localparam logic [Y_W-1:0] C_RST  = Y_W'(Y_RST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= C_RST;
    end else if (tick && en && (up != dn)) begin
      if (up) begin
        y <= (y < C_STEP) ? '0 : (y - C_STEP);
      end else begin
        y <= (y > (C_MAX - C_STEP)) ? C_MAX : (y + C_STEP);
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Purpose: per-frame pong sequencer: ball/paddle motion, collisions, score, match FSM.
// Latency: all outputs registered; frame updates visible 1 clk after frame_tick.
// Backpressure: none; a frame_tick landing in the 1-clk POINT state is dropped.
//
// Ports: clk, rst_n (async active-low); frame_tick (1-clk pulse per frame);
// btn_start (level, honoured in IDLE/OVER on frame_tick); p1_up/p1_dn,
// p2_up/p2_dn (paddle levels); ball_x/ball_y (ball top-left); pad1_y/pad2_y
// (paddle top edges); score1/score2; game_state (state_t); winner (valid in OVER).
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int BALL_SZ   = 8,
  parameter int PAD_W     = 8,
  parameter int PAD_H     = 64,
  parameter int PAD1_X    = 16,
  parameter int PAD2_X    = 616,
  parameter int PAD_SPD   = 4,
  parameter int BALL_SPD  = 2,
  parameter int WIN_SCORE = 7,
  parameter int SERVE_DLY = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               btn_start,
  input  logic               p1_up,
  input  logic               p1_dn,
  input  logic               p2_up,
  input  logic               p2_dn,
  output logic [X_W-1:0]     ball_x,
  output logic [Y_W-1:0]     ball_y,
  output logic [Y_W-1:0]     pad1_y,
  output logic [Y_W-1:0]     pad2_y,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [2:0]         game_state,
  output logic               winner
);

  localparam logic [CALC_W-1:0]  C_H_RES   = CALC_W'(H_RES);
  localparam logic [CALC_W-1:0]  C_V_RES   = CALC_W'(V_RES);
  localparam logic [CALC_W-1:0]  C_SZ      = CALC_W'(BALL_SZ);
  localparam logic [CALC_W-1:0]  C_PAD_H   = CALC_W'(PAD_H);
  localparam logic [CALC_W-1:0]  C_P1_FACE = CALC_W'(PAD1_X + PAD_W);
  localparam logic [CALC_W-1:0]  C_P2_X    = CALC_W'(PAD2_X);
  localparam logic [CALC_W-1:0]  C_SPD     = CALC_W'(BALL_SPD);
  localparam logic [X_W-1:0]     BALL_X0   = X_W'((H_RES - BALL_SZ) / 2);
  localparam logic [Y_W-1:0]     BALL_Y0   = Y_W'((V_RES - BALL_SZ) / 2);
  localparam logic [CTR_W-1:0]   C_DLY     = CTR_W'(SERVE_DLY);
  localparam logic [SCORE_W-1:0] C_WIN     = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] C_ONE     = SCORE_W'(1);

  state_t             state, state_n;
  logic [X_W-1:0]     ball_x_q, ball_x_n;
  logic [Y_W-1:0]     ball_y_q, ball_y_n;
  logic               dir_x, dir_x_n;
  logic               dir_y, dir_y_n;
  logic [SCORE_W-1:0] score1_q, score1_n;
  logic [SCORE_W-1:0] score2_q, score2_n;
  logic               winner_q, winner_n;
  logic [CTR_W-1:0]   ctr, ctr_n;

  logic               pad_en;
  logic [Y_W-1:0]     pad1_q, pad2_q;

  // ---------------------------------------------------------------------
  // Paddles
  // ---------------------------------------------------------------------
  assign pad_en = (state == ST_SERVE) || (state == ST_PLAY);

  pong_paddle #(
    .STEP     (PAD_SPD),
    .CLAMP_MAX(V_RES - PAD_H),
    .Y_RST    ((V_RES - PAD_H) / 2)
  ) u_pad1 (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (frame_tick),
    .en   (pad_en),
    .up   (p1_up),
    .dn   (p1_dn),
    .y    (pad1_q)
  );

  pong_paddle #(
    .STEP     (PAD_SPD),
    .CLAMP_MAX(V_RES - PAD_H),
    .Y_RST    ((V_RES - PAD_H) / 2)
  ) u_pad2 (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (frame_tick),
    .en   (pad_en),
    .up   (p2_up),
    .dn   (p2_dn),
    .y    (pad2_q)
  );

  // ---------------------------------------------------------------------
  // Candidate ball motion for one PLAY frame. Both axes are derived from
  // the same old position, and the hit tests use the paddle positions
  // from before this frame's paddle step.
  // ---------------------------------------------------------------------
  logic [CALC_W-1:0] bx, by, p1, p2;
  logic [CALC_W-1:0] x_mv, y_mv;
  logic              dx_mv, dy_mv, miss;
  logic              ov1, ov2;

  assign bx  = CALC_W'(ball_x_q);
  assign by  = CALC_W'(ball_y_q);
  assign p1  = CALC_W'(pad1_q);
  assign p2  = CALC_W'(pad2_q);
  assign ov1 = span_overlap(by, C_SZ, p1, C_PAD_H);
  assign ov2 = span_overlap(by, C_SZ, p2, C_PAD_H);

  always_comb begin
    y_mv  = by;
    dy_mv = dir_y;
    if (dir_y == DIR_UP) begin
      if (by < C_SPD) begin
        y_mv  = '0;
        dy_mv = DIR_DOWN;
      end else begin
        y_mv = by - C_SPD;
      end
    end else if ((by + C_SZ + C_SPD) > C_V_RES) begin
      y_mv  = C_V_RES - C_SZ;
      dy_mv = DIR_UP;
    end else begin
      y_mv = by + C_SPD;
    end

    x_mv  = bx;
    dx_mv = dir_x;
    miss  = 1'b0;
    if (dir_x == DIR_LEFT) begin
      // Hit only on the frame the ball would cross the paddle face.
      if ((bx >= C_P1_FACE) && (bx < (C_P1_FACE + C_SPD)) && ov1) begin
        x_mv  = C_P1_FACE;
        dx_mv = DIR_RIGHT;
      end else if (bx < C_SPD) begin
        miss = 1'b1;
      end else begin
        x_mv = bx - C_SPD;
      end
    end else begin
      if (((bx + C_SZ) <= C_P2_X) && ((bx + C_SZ + C_SPD) > C_P2_X) && ov2) begin
        x_mv  = C_P2_X - C_SZ;
        dx_mv = DIR_LEFT;
      end else if ((bx + C_SZ + C_SPD) > C_H_RES) begin
        miss = 1'b1;
      end else begin
        x_mv = bx + C_SPD;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Match FSM, ball and score next-state
  // ---------------------------------------------------------------------
  always_comb begin
    state_n  = state;
    ball_x_n = ball_x_q;
    ball_y_n = ball_y_q;
    dir_x_n  = dir_x;
    dir_y_n  = dir_y;
    score1_n = score1_q;
    score2_n = score2_q;
    winner_n = winner_q;
    ctr_n    = ctr;

    unique case (state)
      ST_IDLE: begin
        ball_x_n = BALL_X0;
        ball_y_n = BALL_Y0;
        if (frame_tick && btn_start) begin
          state_n = ST_SERVE;
          ctr_n   = C_DLY;
        end
      end

      ST_SERVE: begin
        ball_x_n = BALL_X0;
        ball_y_n = BALL_Y0;
        if (frame_tick) begin
          if (ctr == '0) begin
            state_n = ST_PLAY;
          end else begin
            ctr_n = ctr - 1'b1;
          end
        end
      end

      ST_PLAY: begin
        if (frame_tick) begin
          ball_y_n = Y_W'(y_mv);
          dir_y_n  = dy_mv;
          if (miss) begin
            state_n = ST_POINT;
          end else begin
            ball_x_n = X_W'(x_mv);
            dir_x_n  = dx_mv;
          end
        end
      end

      ST_POINT: begin
        // dir_x is left untouched on a miss, so it names the side that
        // conceded: moving left means the right player scored. It is also
        // already the serve direction (toward the conceder).
        ball_x_n = BALL_X0;
        ball_y_n = BALL_Y0;
        ctr_n    = C_DLY;
        if (dir_x == DIR_LEFT) begin
          score2_n = score2_q + C_ONE;
          if (score2_n == C_WIN) begin
            state_n  = ST_OVER;
            winner_n = 1'b1;
          end else begin
            state_n = ST_SERVE;
          end
        end else begin
          score1_n = score1_q + C_ONE;
          if (score1_n == C_WIN) begin
            state_n  = ST_OVER;
            winner_n = 1'b0;
          end else begin
            state_n = ST_SERVE;
          end
        end
      end

      ST_OVER: begin
        if (frame_tick && btn_start) begin
          state_n  = ST_SERVE;
          ctr_n    = C_DLY;
          score1_n = '0;
          score2_n = '0;
          winner_n = 1'b0;
          dir_x_n  = DIR_RIGHT;
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ball_x_q <= BALL_X0;
      ball_y_q <= BALL_Y0;
      dir_x    <= DIR_RIGHT;
      dir_y    <= DIR_DOWN;
      score1_q <= '0;
      score2_q <= '0;
      winner_q <= 1'b0;
      ctr      <= '0;
    end else begin
      state    <= state_n;
      ball_x_q <= ball_x_n;
      ball_y_q <= ball_y_n;
      dir_x    <= dir_x_n;
      dir_y    <= dir_y_n;
      score1_q <= score1_n;
      score2_q <= score2_n;
      winner_q <= winner_n;
      ctr      <= ctr_n;
    end
  end

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign pad1_y     = pad1_q;
  assign pad2_y     = pad2_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign game_state = state;
  assign winner     = winner_q;

endmodule
